pe_mac_bidir: RTL and testbench

Next-generation systolic multiply-accumulate processing element for the EKF-SLAM reconfigurable systolic array (RSA). The operand flow is selectable per axis at run time: north-to-south or south-to-north, and west-to-east or east-to-west. Products are signed, full precision and summed in a wide accumulator. Results are scaled by a fixed-point shift, narrowed to the array word width, and drained against the horizontal operand flow. A sticky flag reports a result collision on the drain chain.

---
 rtl/pe_mac_bidir_if.sv | 30 +++
 rtl/pe_mac_bidir.sv | 140 ++++++++++++++
 tb/tb_pe_mac_bidir.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_bidir_if.sv
// Port bundle of one pe_mac_bidir: operand, marker and result buses for both sides of each axis.
// Slice 0 of every two-side bus is the N/W side, slice 1 the S/E side.
interface pe_mac_bidir_if #(
    parameter int RSA_DW = 16
);
    logic [1:0]          PE_mode;
    logic [1:0]          cal_en_i;
    logic [1:0]          cal_en_o;
    logic [1:0]          cal_done_i;
    logic [1:0]          cal_done_o;
    logic [2*RSA_DW-1:0] v_data_i;
    logic [2*RSA_DW-1:0] v_data_o;
    logic [2*RSA_DW-1:0] h_data_i;
    logic [2*RSA_DW-1:0] h_data_o;
    logic [1:0]          mulres_val_i;
    logic [1:0]          mulres_val_o;
    logic [2*RSA_DW-1:0] mulres_i;
    logic [2*RSA_DW-1:0] mulres_o;
    logic                collide;

    modport master (
        output PE_mode, cal_en_i, cal_done_i, v_data_i, h_data_i, mulres_val_i, mulres_i,
        input  cal_en_o, cal_done_o, v_data_o, h_data_o, mulres_val_o, mulres_o, collide
    );

    modport slave (
        input  PE_mode, cal_en_i, cal_done_i, v_data_i, h_data_i, mulres_val_i, mulres_i,
        output cal_en_o, cal_done_o, v_data_o, h_data_o, mulres_val_o, mulres_o, collide
    );
endinterface

// File: rtl/pe_mac_bidir.sv
// Bidirectional systolic MAC PE: run-time selectable operand flow per axis, results drained against h flow.
// Define PE_MAC_SAT_EN to saturate the narrowed result instead of wrapping it.
module pe_mac_bidir #(
    parameter int RSA_DW    = 16,
    parameter int ACC_DW    = 2*RSA_DW+8,
    parameter int FRAC_BITS = 0
) (
    input  logic          clk,
    input  logic          sys_rst,
    pe_mac_bidir_if.slave bus
);
    localparam int PW = 2*RSA_DW;

    logic [1:0]               mode_r;
    logic                     mode_chg, v_side, h_side;
    logic                     en, done, in_val, out_val;
    logic signed [RSA_DW-1:0] v_op, h_op;
    logic [RSA_DW-1:0]        in_res, local_res, res_word;
    logic signed [PW-1:0]     prod_r, prod_nxt;
    logic signed [ACC_DW-1:0] acc_r, acc_nxt, sum, scaled;
    logic [1:0]               cal_en_r, cal_en_nxt, cal_done_r, cal_done_nxt, val_r, val_nxt;
    logic [PW-1:0]            v_r, v_nxt, h_r, h_nxt, res_r, res_nxt;
    logic                     collide_r, collide_nxt;

    assign v_side   = bus.PE_mode[0];
    assign h_side   = bus.PE_mode[1];
    assign mode_chg = (bus.PE_mode != mode_r);

    always_comb begin
        en     = bus.cal_en_i[v_side];
        done   = bus.cal_done_i[v_side];
        v_op   = v_side ? bus.v_data_i[PW-1:RSA_DW] : bus.v_data_i[RSA_DW-1:0];
        h_op   = h_side ? bus.h_data_i[PW-1:RSA_DW] : bus.h_data_i[RSA_DW-1:0];
        in_val = bus.mulres_val_i[~h_side];
        in_res = h_side ? bus.mulres_i[RSA_DW-1:0] : bus.mulres_i[PW-1:RSA_DW];
    end

    // The closing cycle's result includes the product still in flight in prod_r.
    assign sum    = acc_r + ACC_DW'(prod_r);
    assign scaled = sum >>> FRAC_BITS;

`ifdef PE_MAC_SAT_EN
    localparam logic signed [ACC_DW-1:0] SAT_MAX = {{(ACC_DW-RSA_DW+1){1'b0}}, {(RSA_DW-1){1'b1}}};
    localparam logic signed [ACC_DW-1:0] SAT_MIN = {{(ACC_DW-RSA_DW+1){1'b1}}, {(RSA_DW-1){1'b0}}};

    always_comb begin
        if (scaled > SAT_MAX)
            local_res = {1'b0, {(RSA_DW-1){1'b1}}};
        else if (scaled < SAT_MIN)
            local_res = {1'b1, {(RSA_DW-1){1'b0}}};
        else
            local_res = scaled[RSA_DW-1:0];
    end
`else
    logic unused_hi;
    assign local_res = scaled[RSA_DW-1:0];
    assign unused_hi = ^scaled[ACC_DW-1:RSA_DW];
`endif

    always_comb begin
        if (en)
            prod_nxt = h_op * v_op;
        else
            prod_nxt = '0;
        acc_nxt      = done ? '0 : sum;
        out_val      = done | in_val;
        res_word     = done ? local_res : (in_val ? in_res : '0);
        collide_nxt  = collide_r | (done & in_val);
        cal_en_nxt   = '0;
        cal_done_nxt = '0;
        v_nxt        = '0;
        h_nxt        = '0;
        val_nxt      = '0;
        res_nxt      = '0;
        if (v_side) begin
            cal_en_nxt[0]   = en;
            cal_done_nxt[0] = done;
            if (en) v_nxt[RSA_DW-1:0] = v_op;
        end else begin
            cal_en_nxt[1]   = en;
            cal_done_nxt[1] = done;
            if (en) v_nxt[PW-1:RSA_DW] = v_op;
        end
        if (h_side) begin
            if (en) h_nxt[RSA_DW-1:0] = h_op;
            val_nxt[1]            = out_val;
            res_nxt[PW-1:RSA_DW]  = res_word;
        end else begin
            if (en) h_nxt[PW-1:RSA_DW] = h_op;
            val_nxt[0]            = out_val;
            res_nxt[RSA_DW-1:0]   = res_word;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_r     <= '0;
            prod_r     <= '0;
            acc_r      <= '0;
            cal_en_r   <= '0;
            cal_done_r <= '0;
            v_r        <= '0;
            h_r        <= '0;
            val_r      <= '0;
            res_r      <= '0;
            collide_r  <= 1'b0;
        end else begin
            mode_r <= bus.PE_mode;
            if (mode_chg) begin
                prod_r     <= '0;
                acc_r      <= '0;
                cal_en_r   <= '0;
                cal_done_r <= '0;
                v_r        <= '0;
                h_r        <= '0;
                val_r      <= '0;
                res_r      <= '0;
                collide_r  <= 1'b0;
            end else begin
                prod_r     <= prod_nxt;
                acc_r      <= acc_nxt;
                cal_en_r   <= cal_en_nxt;
                cal_done_r <= cal_done_nxt;
                v_r        <= v_nxt;
                h_r        <= h_nxt;
                val_r      <= val_nxt;
                res_r      <= res_nxt;
                collide_r  <= collide_nxt;
            end
        end
    end

    assign bus.cal_en_o     = cal_en_r;
    assign bus.cal_done_o   = cal_done_r;
    assign bus.v_data_o     = v_r;
    assign bus.h_data_o     = h_r;
    assign bus.mulres_val_o = val_r;
    assign bus.mulres_o     = res_r;
    assign bus.collide      = collide_r;
endmodule

// File: tb/tb_pe_mac_bidir.sv
// Bench for pe_mac_bidir: directed vector table, corner sequences, then random traffic vs. a vector-level model.
// Two instances share stimulus: FRAC_BITS=0 (main checks) and FRAC_BITS=4 (scaling check).
module tb_pe_mac_bidir;
    localparam int DW = 16;

`ifdef PE_MAC_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = 14464;
`endif

    logic clk = 1'b0;
    logic sys_rst;
    always #5 clk = ~clk;

    logic [1:0]    mode, en_i, done_i, mrv_i;
    logic [2*DW-1:0] v_i, h_i, mr_i;

    pe_mac_bidir_if #(.RSA_DW(DW)) bus0 ();
    pe_mac_bidir_if #(.RSA_DW(DW)) bus4 ();

    assign bus0.PE_mode = mode;   assign bus4.PE_mode = mode;
    assign bus0.cal_en_i = en_i;  assign bus4.cal_en_i = en_i;
    assign bus0.cal_done_i = done_i; assign bus4.cal_done_i = done_i;
    assign bus0.v_data_i = v_i;   assign bus4.v_data_i = v_i;
    assign bus0.h_data_i = h_i;   assign bus4.h_data_i = h_i;
    assign bus0.mulres_val_i = mrv_i; assign bus4.mulres_val_i = mrv_i;
    assign bus0.mulres_i = mr_i;  assign bus4.mulres_i = mr_i;

    pe_mac_bidir #(.RSA_DW(DW), .ACC_DW(2*DW+8), .FRAC_BITS(0)) dut0 (
        .clk(clk), .sys_rst(sys_rst), .bus(bus0));
    pe_mac_bidir #(.RSA_DW(DW), .ACC_DW(2*DW+8), .FRAC_BITS(4)) dut4 (
        .clk(clk), .sys_rst(sys_rst), .bus(bus4));

    typedef struct {
        logic [1:0]      mode, en, done, mrv;
        logic [2*DW-1:0] v, h, mr;
        logic [1:0]      xval;
        logic [2*DW-1:0] xres;
        logic            xcol;
    } vec_t;

    vec_t tbl[21];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [2*DW-1:0] w2(input int hi, input int lo);
        logic [DW-1:0] a, b;
        a = hi[DW-1:0];
        b = lo[DW-1:0];
        return {a, b};
    endfunction

    function automatic vec_t mk(input logic [1:0] md, input logic [1:0] en, input logic [1:0] dn,
                                input int v1, input int v0, input int h1, input int h0,
                                input logic [1:0] mrv, input int m1, input int m0,
                                input logic [1:0] xv, input int x1, input int x0, input logic xc);
        vec_t r;
        r.mode = md; r.en = en; r.done = dn; r.mrv = mrv;
        r.v = w2(v1, v0); r.h = w2(h1, h0); r.mr = w2(m1, m0);
        r.xval = xv; r.xres = w2(x1, x0); r.xcol = xc;
        return r;
    endfunction

    // Scale and narrow an exact sum the way the result word is defined.
    function automatic logic [DW-1:0] narrow(input longint s, input int frac);
        longint sc;
        sc = s >>> frac;
`ifdef PE_MAC_SAT_EN
        if (sc > 32767)  return 16'h7fff;
        if (sc < -32768) return 16'h8000;
`endif
        return sc[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        en_i = '0; done_i = '0; mrv_i = '0; v_i = '0; h_i = '0; mr_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random-phase reference state
    logic [1:0]      pm;
    longint          rs;
    logic            mcol;

    initial begin
        // mode, en, done, v{S,N}, h{E,W}, mrv, mr{E,W}, expected val, res{E,W}, collide
        tbl[0]  = mk(2'b00, 2'b01, 2'b00, 0, 3,   0, 2,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[1]  = mk(2'b00, 2'b01, 2'b00, 0, 5,   0, 4,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[2]  = mk(2'b00, 2'b01, 2'b00, 0, 6,   0, -1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[3]  = mk(2'b00, 2'b00, 2'b01, 0, 0,   0, 0,   2'b00, 0, 0, 2'b01, 0, 20, 0);
        tbl[4]  = mk(2'b00, 2'b00, 2'b00, 0, 0,   0, 0,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[5]  = mk(2'b00, 2'b01, 2'b00, 0, 200, 0, 200, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[6]  = mk(2'b00, 2'b01, 2'b00, 0, 200, 0, 200, 2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[7]  = mk(2'b00, 2'b00, 2'b01, 0, 0,   0, 0,   2'b00, 0, 0, 2'b01, 0, SAT_EXP, 0);
        tbl[8]  = mk(2'b00, 2'b00, 2'b00, 0, 0,   0, 0,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[9]  = mk(2'b00, 2'b01, 2'b00, 0, 3,   0, 2,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[10] = mk(2'b00, 2'b01, 2'b00, 0, 5,   0, 4,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[11] = mk(2'b00, 2'b01, 2'b00, 0, 6,   0, -1,  2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[12] = mk(2'b00, 2'b00, 2'b01, 0, 0,   0, 0,   2'b10, 7, 0, 2'b01, 0, 20, 1);
        tbl[13] = mk(2'b00, 2'b00, 2'b00, 0, 0,   0, 0,   2'b10, 9, 0, 2'b01, 0, 9, 1);
        tbl[14] = mk(2'b00, 2'b00, 2'b00, 0, 0,   0, 0,   2'b00, 0, 0, 2'b00, 0, 0, 1);
        tbl[15] = mk(2'b11, 2'b00, 2'b00, 0, 0,   0, 0,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[16] = mk(2'b11, 2'b10, 2'b00, 3, 0,   2, 0,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[17] = mk(2'b11, 2'b10, 2'b00, 5, 0,   4, 0,   2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[18] = mk(2'b11, 2'b10, 2'b00, 6, 0,   -1, 0,  2'b00, 0, 0, 2'b00, 0, 0, 0);
        tbl[19] = mk(2'b11, 2'b00, 2'b10, 0, 0,   0, 0,   2'b00, 0, 0, 2'b10, 20, 0, 0);
        tbl[20] = mk(2'b11, 2'b00, 2'b00, 0, 0,   0, 0,   2'b01, 0, -5, 2'b10, -5, 0, 0);

        mode = 2'b00;
        idle();
        sys_rst = 1'b1;
        #12;
        check("reset_res", {bus0.mulres_val_o, bus0.mulres_o}, '0);
        check("reset_fwd", {bus0.cal_en_o, bus0.cal_done_o, bus0.v_data_o, bus0.h_data_o, bus0.collide}, '0);
        @(negedge clk);
        sys_rst = 1'b0;
        tick();

        // Fractional scaling: -3*5 = -15, floor(-15/16) = -1
        en_i = 2'b01; v_i = w2(0, 5); h_i = w2(0, -3);
        tick();
        idle(); done_i = 2'b01;
        tick();
        check("frac4_res", {bus4.mulres_val_o, bus4.mulres_o}, {2'b01, w2(0, -1)});
        check("frac0_res", {bus0.mulres_val_o, bus0.mulres_o}, {2'b01, w2(0, -15)});
        idle();
        tick();

        for (int i = 0; i < 21; i++) begin
            mode = tbl[i].mode; en_i = tbl[i].en; done_i = tbl[i].done;
            v_i = tbl[i].v; h_i = tbl[i].h; mrv_i = tbl[i].mrv; mr_i = tbl[i].mr;
            tick();
            check($sformatf("tbl%0d_val", i), bus0.mulres_val_o, tbl[i].xval);
            check($sformatf("tbl%0d_res", i), bus0.mulres_o, tbl[i].xres);
            check($sformatf("tbl%0d_col", i), bus0.collide, tbl[i].xcol);
        end

        // Mode 11 echo: S/E operands reappear on N/W one cycle later
        idle(); en_i = 2'b10; v_i = w2(16'h1234, 0); h_i = w2(16'h0abc, 0);
        tick();
        check("echo_en", bus0.cal_en_o, 2'b01);
        check("echo_v", bus0.v_data_o, w2(0, 16'h1234));
        check("echo_h", bus0.h_data_o, w2(0, 16'h0abc));
        idle();
        tick();
        check("echo_gap", {bus0.cal_en_o, bus0.v_data_o, bus0.h_data_o}, '0);

        // Asynchronous reset in the middle of a vector
        en_i = 2'b10; v_i = w2(7, 0); h_i = w2(7, 0);
        tick();
        #3 sys_rst = 1'b1;
        #1;
        check("arst_fwd", {bus0.cal_en_o, bus0.v_data_o, bus0.h_data_o}, '0);
        check("arst_res", {bus0.mulres_val_o, bus0.mulres_o, bus0.collide}, '0);
        mode = 2'b00;
        idle();
        @(posedge clk);
        #1 sys_rst = 1'b0;
        en_i = 2'b01; v_i = w2(0, 1); h_i = w2(0, 1);
        tick();
        idle(); done_i = 2'b01;
        tick();
        check("arst_fresh", {bus0.mulres_val_o, bus0.mulres_o}, {2'b01, w2(0, 1)});
        idle();
        tick();

        pm = 2'b00; rs = 0; mcol = 1'b0;
        for (int c = 0; c < 600; c++) begin
            logic [1:0]      xen, xdone, xval;
            logic [2*DW-1:0] xv, xh, xres;
            logic [DW-1:0]   vop, hop, inr;
            logic            vs, hs, e, d, inv;
            int              vo, ho;
            longint          p;
            if ($urandom_range(0, 40) == 0) mode = 2'($urandom_range(0, 3));
            en_i   = 2'($urandom_range(0, 3));
            done_i = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
            mrv_i  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            v_i = $urandom; h_i = $urandom; mr_i = $urandom;

            xen = '0; xdone = '0; xval = '0; xv = '0; xh = '0; xres = '0;
            if (mode != pm) begin
                rs = 0; mcol = 1'b0;
            end else begin
                vs = mode[0]; hs = mode[1];
                e = en_i[vs]; d = done_i[vs];
                vop = vs ? v_i[31:16] : v_i[15:0];
                hop = hs ? h_i[31:16] : h_i[15:0];
                inv = mrv_i[!hs];
                inr = hs ? mr_i[15:0] : mr_i[31:16];
                vo = vs ? 0 : 1;
                ho = hs ? 0 : 1;
                xen[vo] = e; xdone[vo] = d;
                if (e) begin
                    xv[vo*DW +: DW] = vop;
                    xh[ho*DW +: DW] = hop;
                end
                p = e ? longint'($signed(vop)) * longint'($signed(hop)) : 0;
                if (d) begin
                    xval[hs] = 1'b1;
                    xres[(1-ho)*DW +: DW] = narrow(rs, 0);
                    if (inv) mcol = 1'b1;
                    rs = p;
                end else begin
                    if (inv) begin
                        xval[hs] = 1'b1;
                        xres[(1-ho)*DW +: DW] = inr;
                    end
                    rs = rs + p;
                end
            end
            pm = mode;
            tick();
            check("rnd_ctl", {bus0.cal_en_o, bus0.cal_done_o}, {xen, xdone});
            check("rnd_vdata", bus0.v_data_o, xv);
            check("rnd_hdata", bus0.h_data_o, xh);
            check("rnd_res", {bus0.mulres_val_o, bus0.mulres_o}, {xval, xres});
            check("rnd_col", bus0.collide, mcol);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
